trng_byte_harvester: RTL and testbench
======================================

// Module: trng_byte_harvester
// PURPOSE
//  Downstream stage of the icestick TRNG LFSR: consumes the raw 1-bit random stream,
//  applies von Neumann debiasing, packs accepted bits into bytes and buffers them in a
//  FIFO with a valid/ready output for the UART transmit path. Overflowed bytes are dropped and counted.
// PARAMETERS
//  DEPTH      16  FIFO depth in bytes; power of two, >= 2
//  DEBIAS     1   1 = von Neumann pair filter; 0 = every valid input bit goes straight to the packer
//  RCT_LIMIT  32  repetition-count threshold for the health test (used only with the macro)
// PORTS
//  clock        in   1  system clock (12 MHz)
//  reset        in   1  asynchronous, active-high reset
//  in_bit       in   1  raw random bit from the LFSR stage
//  in_valid     in   1  in_bit qualifier; one bit is consumed per cycle when high, no backpressure
//  out_data     out  8  FIFO head byte (first-word fall-through)
//  out_valid    out  1  FIFO not empty
//  out_ready    in   1  consumer accepts out_data this cycle
//  drop_cnt     out  8  saturating count of bytes lost to a full FIFO
//  fifo_level   out  $clog2(DEPTH)+1  current occupancy
//  health_fail  out  1  sticky health-test failure flag
// BEHAVIOUR
//  Reset: all state clears. out_valid=0, out_data=0, drop_cnt=0, fifo_level=0, health_fail=0,
//   pair FSM in IDLE, packer bit count 0, shift register 0.
//  Pair FSM (DEBIAS=1): IDLE --valid bit a--> HAVE_FIRST(a).
//   HAVE_FIRST(a) --valid bit b--> IDLE. If a!=b, emit a (01->0, 10->1); 00 and 11 emit nothing.
//   Cycles with in_valid=0 hold the state. A pair never spans a reset.
//  Packer: emitted bits shift in LSB-first; bit k of the byte is the k-th emitted bit.
//   The 8th emitted bit forms the byte and pushes it on that same clock edge; the count wraps to 0.
//  FIFO: out_valid asserts on the cycle after the push edge, so latency is 1 cycle from the
//   final in_valid to out_valid when the FIFO was empty.
//   Pop when out_valid && out_ready; out_data holds stable while out_valid && !out_ready.
//  Full: a push is accepted if not full, or if a pop happens in the same cycle (level unchanged).
//   Otherwise the byte is discarded and drop_cnt increments, saturating at 255.
//  Empty: out_ready is ignored and out_data holds its last value (0 after reset).
//  Simultaneous push+pop when not full or empty: level unchanged, data order preserved.
//  Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
//  Reset asserted mid-byte or mid-pair: partial byte and pending pair bit are discarded and FIFO contents are lost.
// CONFIGURATION
//  TRNG_HEALTH_TEST_EN defined:
//   - A repetition-count test runs on raw in_bit (before debias): a run counter increments on each
//     valid bit equal to the previous one and reloads to 1 on a change.
//   - When the run reaches RCT_LIMIT, health_fail sets (sticky until reset) and the partial byte is discarded.
//   - While health_fail=1 there are no further pushes; the FIFO still drains.
//  Macro undefined: the test logic is absent and health_fail is tied 0. The port remains.
// STRUCTURE
//  Shared package trng_pkg: BYTE_W=8, the pair FSM state typedef (IDLE, HAVE_FIRST),
//   and DROP_CNT_MAX=8'hFF.
//  One sub-module: trng_byte_fifo (sync FWFT FIFO, DEPTH parameter, push/pop/full/empty/level).
//   The debias FSM, packer and health test stay in the top module.
// TESTING
//  1. Reset, DEBIAS=1, in_bit pairs 10,01,10,10,01,01,01,10 -> out_data=8'h8D (bits 1,0,1,1,0,0,0,1 LSB-first),
//     out_valid rises 1 cycle after the last pair.
//  2. Pairs 00 and 11 interleaved, in_valid gaps -> no emitted bits, no push; FSM resumes the correct pair after a gap.
//  3. out_ready=0, feed 17 bytes with DEPTH=16 -> fifo_level=16, drop_cnt=1;
//     a push plus pop on a full FIFO -> drop_cnt unchanged.
//  4. Feed 300 overflow bytes -> drop_cnt saturates at 255.
//  5. Assert reset after 5 packed bits and with 3 bytes queued -> out_valid=0, level=0;
//     the next byte is built from 8 fresh bits.
//  6. With TRNG_HEALTH_TEST_EN and RCT_LIMIT=32, 32 consecutive 1s -> health_fail=1 and no further pushes;
//     31 ones then a 0 -> health_fail stays 0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG byte harvester: byte width, the
// von Neumann pair FSM states and the drop-counter ceiling.
package trng_pkg;

    localparam int         BYTE_W       = 8;
    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    typedef enum logic {
        IDLE,
        HAVE_FIRST
    } pair_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == DROP_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/trng_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. The head byte is held in a
// register, so it keeps its last value while the FIFO is empty.
module trng_byte_fifo
    import trng_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_push_data,
    input  logic              i_pop_ready,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [AW:0]       o_level
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW + 1)'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("trng_byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [BYTE_W-1:0] r_head;

    logic              w_pop;
    logic              w_write;
    logic [AW-1:0]     w_rd_next;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == FULL_LEVEL);
    assign w_pop     = !o_empty && i_pop_ready;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign w_write   = i_push && (!o_full || w_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    // NOTE: the storage array has no reset; only pointers, level and head are
    // reset, so the array can map onto plain RAM or LUT memory.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + ONE_LEVEL;
                2'b01:   r_level <= r_level - ONE_LEVEL;
                default: r_level <= r_level;
            endcase
            // The next head comes from memory unless the byte being written is it.
            if (w_pop) begin
                if (r_level > ONE_LEVEL) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_write) begin
                    r_head <= i_push_data;
                end
            end else if (o_empty && w_write) begin
                r_head <= i_push_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_level = r_level;

endmodule

// File: rtl/trng_byte_harvester.sv
// Raw TRNG bit stream -> von Neumann debias -> LSB-first byte packer -> FIFO.
// Optional repetition-count health test enabled by TRNG_HEALTH_TEST_EN.
module trng_byte_harvester
    import trng_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DEBIAS    = 1,
    parameter int RCT_LIMIT = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_bit,
    input  logic                     in_valid,
    output logic [BYTE_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     health_fail
);

    localparam int CNT_W = $clog2(BYTE_W);

    if (RCT_LIMIT < 2) begin : g_bad_rct
        $error("trng_byte_harvester: RCT_LIMIT must be at least 2");
    end

    pair_state_t        r_pair_state;
    logic               r_first_bit;
    logic [BYTE_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [7:0]         r_drop_cnt;

    logic               w_emit;
    logic               w_emit_bit;
    logic [BYTE_W-1:0]  w_shift_next;
    logic               w_byte_done;
    logic               w_push;
    logic               w_hold_off;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pair_state <= IDLE;
            r_first_bit  <= 1'b0;
        end else if (in_valid) begin
            case (r_pair_state)
                IDLE: begin
                    r_pair_state <= HAVE_FIRST;
                    r_first_bit  <= in_bit;
                end
                default: r_pair_state <= IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        w_emit     = 1'b0;
        w_emit_bit = in_bit;
        if (DEBIAS != 0) begin
            // 01 -> 0, 10 -> 1: the emitted bit is the first bit of an unequal pair.
            w_emit     = in_valid && (r_pair_state == HAVE_FIRST) && (in_bit != r_first_bit);
            w_emit_bit = r_first_bit;
        end else begin
            w_emit     = in_valid;
        end
    end

`ifdef TRNG_HEALTH_TEST_EN
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RCT_LIMIT);

    logic [RUN_W-1:0] r_run_cnt;
    logic             r_prev_bit;
    logic             r_health_fail;
    logic [RUN_W-1:0] w_run_next;
    logic             w_rct_trip;

    // A zero run count marks "no previous bit yet", so the first bit starts a run of 1.
    always_comb begin
        w_run_next = RUN_W'(1);
        if ((r_run_cnt != '0) && (in_bit == r_prev_bit)) begin
            w_run_next = (r_run_cnt == RUN_LIMIT) ? r_run_cnt : r_run_cnt + RUN_W'(1);
        end
    end

    assign w_rct_trip = in_valid && (w_run_next == RUN_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_cnt     <= '0;
            r_prev_bit    <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (in_valid) begin
            r_run_cnt  <= w_run_next;
            r_prev_bit <= in_bit;
            if (w_rct_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    assign w_hold_off  = r_health_fail || w_rct_trip;
    assign health_fail = r_health_fail;
`else
    assign w_hold_off  = 1'b0;
    assign health_fail = 1'b0;
`endif

    // New bits enter at the MSB and move down, so after eight shifts the
    // first emitted bit sits in bit 0.
    assign w_shift_next = {w_emit_bit, r_shift[BYTE_W-1:1]};
    assign w_byte_done  = w_emit && (r_bit_cnt == CNT_W'(BYTE_W - 1));
    assign w_push       = w_byte_done && !w_hold_off;
    assign w_pop        = !w_fifo_empty && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_hold_off) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_emit) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_drop_cnt <= sat_inc8(r_drop_cnt);
        end
    end

    trng_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_shift_next),
        .i_pop_ready (out_ready),
        .o_data      (out_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_level     (fifo_level)
    );

    assign out_valid = !w_fifo_empty;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_trng_byte_harvester.sv
// Directed, table-driven bench for trng_byte_harvester (DEPTH=16, DEBIAS=1).
module tb_trng_byte_harvester;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_bit;
    logic          in_valid;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    drop_cnt;
    logic [LW-1:0] fifo_level;
    logic          health_fail;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    trng_byte_harvester #(
        .DEPTH     (DEPTH),
        .DEBIAS    (1),
        .RCT_LIMIT (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .drop_cnt    (drop_cnt),
        .fifo_level  (fifo_level),
        .health_fail (health_fail)
    );

    // Pair k of a vector is (first[k], second[k]); gap[k] inserts an idle
    // cycle between the two bits of that pair.
    typedef struct {
        logic [11:0] first;
        logic [11:0] second;
        logic [11:0] gap;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic raw_bit(input logic b);
        in_bit   = b;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) begin
            raw_bit(v[k]);
            raw_bit(~v[k]);
        end
    endtask

    // Same as send_byte, but out_ready is high on the edge that pushes the byte.
    task automatic send_byte_with_pop(input logic [7:0] v);
        for (int k = 0; k < 7; k++) begin
            raw_bit(v[k]);
            raw_bit(~v[k]);
        end
        raw_bit(v[7]);
        out_ready = 1'b1;
        raw_bit(~v[7]);
        out_ready = 1'b0;
    endtask

    task automatic pop_one;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q [$];
        logic [7:0] v;

        vecs[0] = '{first: 12'h4E3, second: 12'h939, gap: 12'h0A4, exp_valid: 1'b1, exp_data: 8'h59};
        vecs[1] = '{first: 12'h59C, second: 12'h62B, gap: 12'hFFF, exp_valid: 1'b1, exp_data: 8'h6C};
        vecs[2] = '{first: 12'hA5C, second: 12'hA5C, gap: 12'h010, exp_valid: 1'b0, exp_data: 8'h6C};
        vecs[3] = '{first: 12'h5C3, second: 12'h53C, gap: 12'h000, exp_valid: 1'b1, exp_data: 8'hC3};

        reset     = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h00);
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_health", 32'(health_fail), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Pairs 10,01,10,10,01,01,01,10 -> 8'h8D; valid appears right after the last pair.
        send_byte_with_pop(8'h00);
        pop_one();
        do_reset();
        raw_bit(1); raw_bit(0); raw_bit(0); raw_bit(1);
        raw_bit(1); raw_bit(0); raw_bit(1); raw_bit(0);
        raw_bit(0); raw_bit(1); raw_bit(0); raw_bit(1);
        raw_bit(0); raw_bit(1); raw_bit(1);
        check("t1_valid_before_last", 32'(out_valid), 32'd0);
        raw_bit(0);
        check("t1_valid_after_last", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h8D);
        check("t1_level", 32'(fifo_level), 32'd1);
        pop_one();

        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 12; p++) begin
                raw_bit(vecs[i].first[p]);
                if (vecs[i].gap[p]) begin
                    @(negedge clock);
                end
                raw_bit(vecs[i].second[p]);
            end
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_valid));
            pop_one();
            check($sformatf("vec%0d_empty", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(out_data), 32'(vecs[i].exp_data));
        end

        // Fill to full with one overflow, then push+pop on a full FIFO.
        for (int i = 0; i < 17; i++) begin
            v = 8'(i * 37 + 5);
            send_byte(v);
            if (i < 16) q.push_back(v);
        end
        check("t3_level_full", 32'(fifo_level), 32'd16);
        check("t3_drop_one", 32'(drop_cnt), 32'd1);
        check("t3_head", 32'(out_data), 32'(q[0]));
        send_byte_with_pop(8'hE7);
        void'(q.pop_front());
        q.push_back(8'hE7);
        check("t3_pushpop_level", 32'(fifo_level), 32'd16);
        check("t3_pushpop_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_order%0d", i), 32'(out_data), 32'(q[i]));
            pop_one();
        end
        check("t3_drained", 32'(fifo_level), 32'd0);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 16 + 254; i++) begin
            send_byte(8'(i));
        end
        check("t4_drop_254", 32'(drop_cnt), 32'd254);
        for (int i = 0; i < 46; i++) begin
            send_byte(8'(i));
        end
        check("t4_drop_sat", 32'(drop_cnt), 32'd255);
        check("t4_level", 32'(fifo_level), 32'd16);

        // Reset mid-byte and mid-pair with bytes queued.
        out_ready = 1'b1;
        repeat (16) @(negedge clock);
        out_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("t5_level_3", 32'(fifo_level), 32'd3);
        for (int k = 0; k < 5; k++) begin
            raw_bit(1); raw_bit(0);
        end
        raw_bit(1);
        reset = 1'b1;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);
        check("t5_data", 32'(out_data), 32'h00);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_byte(8'hA6);
        check("t5_fresh_valid", 32'(out_valid), 32'd1);
        check("t5_fresh_data", 32'(out_data), 32'hA6);
        check("t5_fresh_level", 32'(fifo_level), 32'd1);
        pop_one();

`ifdef TRNG_HEALTH_TEST_EN
        do_reset();
        repeat (31) raw_bit(1);
        check("t6_31_ones", 32'(health_fail), 32'd0);
        raw_bit(0);
        check("t6_after_zero", 32'(health_fail), 32'd0);
        repeat (31) raw_bit(1);
        check("t6_run31", 32'(health_fail), 32'd0);
        raw_bit(1);
        check("t6_run32", 32'(health_fail), 32'd1);
        send_byte(8'h5A);
        check("t6_no_push_valid", 32'(out_valid), 32'd0);
        check("t6_no_push_level", 32'(fifo_level), 32'd0);
        check("t6_sticky", 32'(health_fail), 32'd1);
`else
        repeat (40) raw_bit(1);
        check("t6_tied_low", 32'(health_fail), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
